// File: rtl/msrv32_instr_queue.sv
// Instruction queue between fetch and decode: a FIFO of {instruction, PC} pairs
// with valid/ready on both sides and decoded fields taken from the head entry.
module msrv32_instr_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             instr_valid_in,
    input  logic [31:0]      instr_in,
    input  logic [PC_W-1:0]  pc_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [31:0]      instr_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [6:0]       opcode_out,
    output logic [2:0]       funct3_out,
    output logic [6:0]       funct7_out,
    output logic [4:0]       rs1_addr_out,
    output logic [4:0]       rs2_addr_out,
    output logic [4:0]       rd_addr_out,
    output logic [11:0]      csr_addr_out,
    output logic [24:0]      instr_31_7_out,
    output logic [CNT_W-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      instr_mem_r [DEPTH];
    logic [PC_W-1:0]  pc_mem_r    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // ready_out depends on occupancy only, so decode never combinationally stalls fetch
    assign ready_out = (count_r != CNT_W'(DEPTH));
    assign valid_out = (count_r != {CNT_W{1'b0}}) && !flush_in;
    assign push_s    = instr_valid_in && ready_out && !flush_in;
    assign pop_s     = valid_out && ready_in;
    assign count_out = count_r;

    // Entry storage; contents are deliberately left untouched by reset and flush
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= instr_in;
            pc_mem_r[wr_ptr_r]    <= pc_in;
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry, replaced by the canonical NOP whenever nothing valid is at the head
    always_comb begin
        instr_out = NOP_INSTR;
        pc_out    = {PC_W{1'b0}};
        if (valid_out) begin
            instr_out = instr_mem_r[rd_ptr_r];
            pc_out    = pc_mem_r[rd_ptr_r];
        end else begin
            instr_out = NOP_INSTR;
            pc_out    = {PC_W{1'b0}};
        end
    end

    assign opcode_out     = instr_out[6:0];
    assign funct3_out     = instr_out[14:12];
    assign funct7_out     = instr_out[31:25];
    assign rs1_addr_out   = instr_out[19:15];
    assign rs2_addr_out   = instr_out[24:20];
    assign rd_addr_out    = instr_out[11:7];
    assign csr_addr_out   = instr_out[31:20];
    assign instr_31_7_out = instr_out[31:7];

endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Self-checking bench for msrv32_instr_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_msrv32_instr_queue;

    localparam int          DEPTH = 4;
    localparam int          PC_W  = 32;
    localparam int          CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             instr_valid_in = 1'b0;
    logic [31:0]      instr_in = 32'h0;
    logic [PC_W-1:0]  pc_in = '0;
    logic             ready_in = 1'b0;
    logic             ready_out;
    logic             valid_out;
    logic [31:0]      instr_out;
    logic [PC_W-1:0]  pc_out;
    logic [6:0]       opcode_out;
    logic [2:0]       funct3_out;
    logic [6:0]       funct7_out;
    logic [4:0]       rs1_addr_out;
    logic [4:0]       rs2_addr_out;
    logic [4:0]       rd_addr_out;
    logic [11:0]      csr_addr_out;
    logic [24:0]      instr_31_7_out;
    logic [CNT_W-1:0] count_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entries are {instr, pc}
    logic [63:0] mq [$];

    msrv32_instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
        .instr_out(instr_out), .pc_out(pc_out), .opcode_out(opcode_out),
        .funct3_out(funct3_out), .funct7_out(funct7_out),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .rd_addr_out(rd_addr_out), .csr_addr_out(csr_addr_out),
        .instr_31_7_out(instr_31_7_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input logic fl);
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_valid = (mq.size() != 0) && !fl;
        e_instr = e_valid ? mq[0][63:32] : NOP;
        e_pc    = e_valid ? mq[0][31:0]  : 32'h0;
        chk("count",  64'(count_out), 64'(mq.size()));
        chk("ready",  64'(ready_out), 64'(mq.size() != DEPTH));
        chk("valid",  64'(valid_out), 64'(e_valid));
        chk("instr",  64'(instr_out), 64'(e_instr));
        chk("pc",     64'(pc_out),    64'(e_pc));
        chk("opcode", 64'(opcode_out), 64'(e_instr[6:0]));
        chk("funct3", 64'(funct3_out), 64'(e_instr[14:12]));
        chk("funct7", 64'(funct7_out), 64'(e_instr[31:25]));
        chk("rs1",    64'(rs1_addr_out), 64'(e_instr[19:15]));
        chk("rs2",    64'(rs2_addr_out), 64'(e_instr[24:20]));
        chk("rd",     64'(rd_addr_out),  64'(e_instr[11:7]));
        chk("csr",    64'(csr_addr_out), 64'(e_instr[31:20]));
        chk("i31_7",  64'(instr_31_7_out), 64'(e_instr[31:7]));
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rs);
        logic do_push;
        logic do_pop;
        instr_valid_in = v;
        instr_in       = ins;
        pc_in          = pc;
        ready_in       = rdy;
        flush_in       = fl;
        rst_in         = rs;
        @(negedge clk_in);
        check_all(fl);
        do_push = v && (mq.size() != DEPTH) && !fl;
        do_pop  = (mq.size() != 0) && !fl && rdy;
        @(posedge clk_in);
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({ins, pc});
        end
        #1;
    endtask

    initial begin
        // Reset, then idle
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        mq.delete();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Single push of addi x5,x5,10, checked against literal field values
        step(1'b1, 32'h00A28293, 32'h100, 1'b0, 1'b0, 1'b0);
        instr_valid_in = 1'b0;
        flush_in = 1'b0;
        #1;
        chk("addi_valid", 64'(valid_out), 64'h1);
        chk("addi_op",    64'(opcode_out), 64'h13);
        chk("addi_rd",    64'(rd_addr_out), 64'h5);
        chk("addi_rs1",   64'(rs1_addr_out), 64'h5);
        chk("addi_31_7",  64'(instr_31_7_out), 64'h0014505);
        chk("addi_pc",    64'(pc_out), 64'h100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill to full, offer a fifth entry, then drain in order
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, 32'h1000_0000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(count_out), 64'(DEPTH));
        chk("full_ready", 64'(ready_out), 64'h0);
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming push+pop across two pointer wraps
        step(1'b1, 32'h2000_0000, 32'h300, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step(1'b1, 32'h2000_0000 + 32'(i), 32'h300 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        chk("stream_count", 64'(count_out), 64'h1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with three entries held and a push offered in the same cycle
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3000_0000 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 32'h500, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream with two entries held
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'h4000_0000 + 32'(i), 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 32'h700, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
